// File: rtl/fifo_word_packer.sv
// Drains bytes from an 8-bit FIFO read port and packs them little-endian into words on a valid/ready output.
// Optional partial-word flush with byte enables is compiled in with `define PACKER_FLUSH_EN.
module fifo_word_packer #(
  parameter int DATA_W         = 8,
  parameter int BYTES_PER_WORD = 4,
  parameter int CNT_W          = 16,
  localparam int WORD_W        = DATA_W * BYTES_PER_WORD
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_W-1:0]         buf_out,
  input  logic                      buf_empty,
  output logic                      rd_en,
  output logic [WORD_W-1:0]         word_out,
  output logic                      word_valid,
  input  logic                      word_ready,
  output logic [CNT_W-1:0]          word_count
`ifdef PACKER_FLUSH_EN
  ,
  input  logic                      flush,
  output logic [BYTES_PER_WORD-1:0] word_be
`endif
);

  localparam int IDX_W = $clog2(BYTES_PER_WORD);
  localparam logic [IDX_W:0]   BPW_L    = (IDX_W+1)'(BYTES_PER_WORD);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);

  typedef enum logic {FILL, HOLD} state_t;

  state_t                    state_q, state_d;
  logic [IDX_W-1:0]          byte_idx_q, byte_idx_d;
  logic                      rd_pending_q, rd_pending_d;
  logic [WORD_W-1:0]         word_q, word_d;
  logic                      word_valid_q, word_valid_d;
  logic [CNT_W-1:0]          count_q, count_d;
  logic [BYTES_PER_WORD-1:0] be_q, be_d;
  logic                      flush_q, flush_d;
  logic [IDX_W:0]            fill_lvl;

  always_comb begin
    state_d      = state_q;
    byte_idx_d   = byte_idx_q;
    word_d       = word_q;
    word_valid_d = word_valid_q;
    count_d      = count_q;
    be_d         = be_q;
    flush_d      = flush_q;

    // Bytes already captured plus the one still in flight bound what we may request.
    fill_lvl     = {1'b0, byte_idx_q} + (IDX_W+1)'(rd_pending_q);
    rd_en        = rst && (state_q == FILL) && !buf_empty && (fill_lvl < BPW_L) && !flush_q;
    rd_pending_d = rd_en;

    case (state_q)
      FILL: begin
        if (rd_pending_q) begin
          for (int i = 0; i < BYTES_PER_WORD; i++) begin
            if (IDX_W'(i) == byte_idx_q) word_d[i*DATA_W +: DATA_W] = buf_out;
          end
          if (byte_idx_q == LAST_IDX) begin
            state_d      = HOLD;
            word_valid_d = 1'b1;
            byte_idx_d   = '0;
            be_d         = '1;
            flush_d      = 1'b0;
          end else begin
            byte_idx_d = byte_idx_q + 1'b1;
          end
        end
`ifdef PACKER_FLUSH_EN
        else if (flush_q) begin
          // Present the partial word once nothing is in flight; unfilled lanes read as zero.
          for (int i = 0; i < BYTES_PER_WORD; i++) begin
            be_d[i] = (IDX_W'(i) < byte_idx_q);
            if (!be_d[i]) word_d[i*DATA_W +: DATA_W] = '0;
          end
          state_d      = HOLD;
          word_valid_d = 1'b1;
          byte_idx_d   = '0;
          flush_d      = 1'b0;
        end
        if (flush && (fill_lvl != '0) && !(rd_pending_q && byte_idx_q == LAST_IDX))
          flush_d = 1'b1;
`endif
      end
      HOLD: begin
        if (word_ready) begin
          word_valid_d = 1'b0;
          count_d      = count_q + 1'b1;
          state_d      = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= FILL;
      byte_idx_q   <= '0;
      rd_pending_q <= 1'b0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
      count_q      <= '0;
      be_q         <= '0;
      flush_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_idx_q   <= byte_idx_d;
      rd_pending_q <= rd_pending_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
      count_q      <= count_d;
      be_q         <= be_d;
      flush_q      <= flush_d;
    end
  end

  assign word_out   = word_q;
  assign word_valid = word_valid_q;
  assign word_count = count_q;
`ifdef PACKER_FLUSH_EN
  assign word_be    = be_q;
`endif

endmodule

// File: tb/tb_fifo_word_packer.sv
// Bench for fifo_word_packer: a queue-based FIFO feeds bytes, a scoreboard of expected words is
// built from the pushed byte stream, and a negedge monitor compares every accepted word.
module tb_fifo_word_packer;
  localparam int BPW = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  buf_out = 8'h00;
  logic        buf_empty = 1'b1;
  logic        rd_en;
  logic [31:0] word_out;
  logic        word_valid;
  logic        word_ready = 1'b0;
  logic [15:0] word_count;
`ifdef PACKER_FLUSH_EN
  logic        flush = 1'b0;
  logic [3:0]  word_be;
`endif

  fifo_word_packer #(.DATA_W(8), .BYTES_PER_WORD(BPW), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .buf_out(buf_out), .buf_empty(buf_empty), .rd_en(rd_en),
    .word_out(word_out), .word_valid(word_valid), .word_ready(word_ready),
    .word_count(word_count)
`ifdef PACKER_FLUSH_EN
    , .flush(flush), .word_be(word_be)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {logic [31:0] w; logic [3:0] be;} exp_t;

  int         tests = 0;
  int         fails = 0;
  int         acc_cnt = 0;
  logic [7:0] fifo_q[$];
  logic [7:0] pend[$];
  exp_t       exp_q[$];
  logic       prev_hold = 1'b0;
  logic [31:0] prev_word = '0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t pack_pend();
    exp_t e;
    e.w  = '0;
    e.be = '0;
    for (int i = 0; i < pend.size(); i++) begin
      e.w[i*8 +: 8] = pend[i];
      e.be[i]       = 1'b1;
    end
    return e;
  endfunction

  // Upstream FIFO: one-cycle read latency, empty flag settles shortly after the edge.
  always @(posedge clk) begin
    if (rd_en && fifo_q.size() > 0) buf_out <= fifo_q.pop_front();
    #1 buf_empty = (fifo_q.size() == 0);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push(logic [7:0] b);
    fifo_q.push_back(b);
    pend.push_back(b);
    if (pend.size() == BPW) begin
      exp_q.push_back(pack_pend());
      pend.delete();
    end
    buf_empty = 1'b0;
  endtask

  task automatic wait_valid(string name, int budget);
    int n = 0;
    while (!word_valid && n < budget) begin
      tick();
      n++;
    end
    chk(name, word_valid, 1'b1);
  endtask

  task automatic wait_idle(string name, int budget);
    int n = 0;
    while ((exp_q.size() != 0 || fifo_q.size() != 0 || word_valid) && n < budget) begin
      tick();
      n++;
    end
    chk(name, exp_q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("reset_rd_en", rd_en, 1'b0);
      chk("reset_word_valid", word_valid, 1'b0);
      chk("reset_word_out", word_out, 32'h0);
      chk("reset_word_count", word_count, 16'h0);
`ifdef PACKER_FLUSH_EN
      chk("reset_word_be", word_be, 4'h0);
`endif
      acc_cnt   = 0;
      prev_hold = 1'b0;
    end else begin
      chk("rd_en_while_empty", rd_en && buf_empty, 1'b0);
      chk("word_count", word_count, 16'(acc_cnt));
      if (word_valid) chk("rd_en_in_hold", rd_en, 1'b0);
      if (prev_hold) begin
        chk("valid_held", word_valid, 1'b1);
        chk("word_stable", word_out, prev_word);
      end
      if (word_valid && word_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", word_out, 32'hxxxxxxxx);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("word_out", word_out, e.w);
`ifdef PACKER_FLUSH_EN
          chk("word_be", word_be, e.be);
`endif
        end
        acc_cnt++;
      end
      prev_hold = word_valid && !word_ready;
      prev_word = word_out;
    end
  end

  initial begin
    // Reset held with data waiting in the FIFO.
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    repeat (3) tick();
    chk("rd_en_in_reset", rd_en, 1'b0);
    rst = 1'b1;
    word_ready = 1'b1;
    #1;
    chk("rd_en_after_release", rd_en, 1'b1);

    // Streaming with immediate acceptance.
    wait_valid("stream_valid_timeout", 20);
    chk("stream_word", word_out, 32'h44332211);
    tick(); tick();
    chk("stream_count", word_count, 16'd1);
    wait_idle("stream_drain", 50);

    // Backpressure: first word held while the second stays in the FIFO.
    word_ready = 1'b0;
    for (int i = 1; i <= 8; i++) push(8'(i * 8'h11));
    wait_valid("bp_valid_timeout", 20);
    repeat (10) tick();
    chk("bp_fifo_level", fifo_q.size(), 4);
    chk("bp_word_held", word_out, 32'h44332211);
    chk("bp_valid_held", word_valid, 1'b1);
    word_ready = 1'b1;
    wait_idle("bp_drain", 50);
    chk("bp_count", word_count, 16'd3);

    // Underrun mid-word.
    push(8'hAA); push(8'hBB);
    repeat (5) tick();
    chk("underrun_no_valid", word_valid, 1'b0);
    push(8'hCC); push(8'hDD);
    wait_idle("underrun_drain", 50);

    // Reset with a partial word packed.
    push(8'h5A); push(8'hA5);
    repeat (5) tick();
    rst = 1'b0;
    pend.delete();
    tick();
    chk("midreset_valid", word_valid, 1'b0);
    chk("midreset_count", word_count, 16'd0);
    rst = 1'b1;
    for (int i = 1; i <= 4; i++) push(8'(i));
    wait_valid("midreset_valid_timeout", 20);
    chk("midreset_word", word_out, 32'h04030201);
    wait_idle("midreset_drain", 50);

`ifdef PACKER_FLUSH_EN
    // Partial word flushed out, then a flush with nothing packed is ignored.
    push(8'h01); push(8'h02); push(8'h03);
    repeat (5) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    exp_q.push_back(pack_pend());
    pend.delete();
    wait_valid("flush_valid_timeout", 20);
    chk("flush_word", word_out, 32'h00030201);
    chk("flush_be", word_be, 4'b0111);
    wait_idle("flush_drain", 50);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    repeat (5) tick();
    chk("flush_empty_ignored", word_valid, 1'b0);
`endif

    // Randomized traffic with random backpressure.
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 3) != 0 && fifo_q.size() < 16) push(8'($urandom));
      word_ready = 1'($urandom_range(0, 1));
      tick();
    end
    while (pend.size() != 0) push(8'($urandom));
    word_ready = 1'b1;
    wait_idle("random_drain", 300);
    chk("final_count", word_count, 16'(acc_cnt));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fifo_word_packer.md
Name: fifo_word_packer

Overview:
- Downstream consumer of the 8-bit circular FIFO.
- Drains bytes via the FIFO read port (rd_en / buf_out / buf_empty) and packs BYTES_PER_WORD consecutive bytes, little-endian, into one output word.
- Presents each word on a valid/ready handshake to the next stage (bus master, width converter).
- Keeps a running count of emitted words for debug/scoreboarding.

Parameters:
- DATA_W, 8, FIFO byte width (must match buf_out).
- BYTES_PER_WORD, 4, bytes per packed word (2..8).
- WORD_W, DATA_W*BYTES_PER_WORD, output word width (derived, not overridden).
- CNT_W, 16, width of the emitted-word counter.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous, active-low reset.
- buf_out  input  DATA_W  FIFO read data, valid one cycle after rd_en.
- buf_empty  input  1  FIFO empty flag.
- rd_en  output  1  FIFO read strobe.
- word_out  output  WORD_W  packed word, byte 0 in bits [DATA_W-1:0].
- word_valid  output  1  word_out holds a complete word.
- word_ready  input  1  downstream accepts word this cycle.
- word_count  output  CNT_W  number of words accepted since reset.

Behaviour:
- Reset (rst=0, asynchronous): state=FILL, byte_idx=0, rd_pending=0, word_out=0, word_valid=0, word_count=0. rd_en is forced 0 while rst=0.
- FIFO read latency is fixed at 1: a byte requested by rd_en in cycle N is captured from buf_out at the edge ending cycle N+1. rd_pending tracks the in-flight read.
- rd_en (combinational) = rst && state==FILL && !buf_empty && (byte_idx + rd_pending) < BYTES_PER_WORD.
  - Never asserted with buf_empty=1.
  - Never over-requests beyond the current word.
  - Back-to-back reads are allowed: 1 byte/cycle sustained.
- Capture: when rd_pending=1 at the edge, buf_out is written to byte lane byte_idx and byte_idx increments.
- State FILL → HOLD on the edge capturing lane BYTES_PER_WORD-1. In the same edge: word_valid<=1, byte_idx<=0.
- HOLD:
  - rd_en=0.
  - word_out and word_valid are stable until accepted.
  - When word_valid && word_ready: word_valid<=0, word_count increments, state<=FILL. The next rd_en can assert the following cycle.
- Handshake rules:
  - word_valid never deasserts without acceptance.
  - word_ready may toggle freely.
  - word_ready with word_valid=0 has no effect.
- word_count wraps modulo 2^CNT_W (all-ones → 0).
- word_out is registered. Lanes not yet written in FILL keep their old contents; only a complete word is ever presented with word_valid=1.
- Reset mid-word: a partially packed word and any in-flight byte are discarded. The FIFO byte already popped is lost by design.
- buf_empty going high mid-word: packing stalls, no timeout, and resumes when data arrives.

Optional Feature:
- Macro PACKER_FLUSH_EN.
- Defined:
  - Adds input flush (1) and output word_be (BYTES_PER_WORD).
  - A flush pulse in FILL with (byte_idx + rd_pending) > 0 is latched.
  - Once rd_pending=0, the partial word is presented in HOLD. Unfilled lanes are zeroed. word_be has a 1 per filled lane.
  - While flush is latched, rd_en is 0.
  - flush with no bytes packed, or in HOLD, is ignored.
  - word_be is all-ones for full words. Reset value of word_be is 0.
- Undefined: no flush or word_be ports; only complete words are emitted.

Test Plan:
- Reset: hold rst=0 with buf_empty=0 → rd_en=0, word_valid=0, word_out=0, word_count=0. Release → rd_en=1 the next cycle.
- Streaming: FIFO holds 0x11,0x22,0x33,0x44, word_ready=1 → rd_en high 4 consecutive cycles, then word_valid=1 with word_out=0x44332211. Accepted the same cycle, word_count=1.
- Backpressure: 8 bytes queued, word_ready=0 for 10 cycles after the first word → word_valid held, word_out=0x44332211 stable, rd_en=0, fifo_counter stays 4. Raise word_ready → second word follows, word_count=2.
- Underrun: 0xAA,0xBB, then FIFO empty 5 cycles, then 0xCC,0xDD → rd_en never high while buf_empty=1; word_out=0xDDCCBBAA.
- Reset mid-word: after 2 bytes captured, pulse rst=0 → word_valid=0, word_count=0. Next 4 bytes 0x01..0x04 → word_out=0x04030201.
- Flush (PACKER_FLUSH_EN): bytes 0x01,0x02,0x03 then flush → word_out=0x00030201, word_be=4'b0111, word_valid=1. word_count=1 after acceptance.
